// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: execute-stage bus between the pipeline (master) and the multiply/divide unit (slave).
interface alu_muldiv_if;
    logic        valid;
    logic [4:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    modport master (output valid, alucontrol, srca, srcb, input hi, lo, busy, done);
    modport slave (input valid, alucontrol, srca, srcb, output hi, lo, busy, done);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Defining ALU_MULDIV_FAST_MULT_EN computes multiplies in a single edge.
module alu_muldiv (
    input  logic        clk,
    input  logic        reset_n,
    alu_muldiv_if.slave bus
);
    localparam logic [4:0] MULTU = 5'b00111;
    localparam logic [4:0] MULT  = 5'b01000;
    localparam logic [4:0] DIV   = 5'b01111;
    localparam logic [4:0] DIVU  = 5'b10000;
    localparam logic [4:0] MTHI  = 5'b10001;
    localparam logic [4:0] MTLO  = 5'b10010;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, next_state, first_state;
    logic [4:0]  count;
    logic        is_div, sa, sb;
    logic [31:0] a_raw, b_mag, hi_q, lo_q;
    logic [63:0] acc, acc_init, acc_step, prod;
    logic        done_q;

    logic [4:0]  op;
    logic        is_mul_in, is_div_in, is_sgn, start, sa_in, sb_in, idle_wr;
    logic [31:0] a_mag_in, b_mag_in;
    logic [32:0] mul_sum, div_r, div_d;
    logic [31:0] quo, rem, hi_fix, lo_fix;

    assign op        = bus.alucontrol;
    assign is_mul_in = op == MULTU || op == MULT;
    assign is_div_in = op == DIV || op == DIVU;
    assign is_sgn    = op == MULT || op == DIV;
    assign idle_wr   = state == IDLE && bus.valid;
    assign start     = idle_wr && (is_mul_in || is_div_in);
    assign sa_in     = is_sgn & bus.srca[31];
    assign sb_in     = is_sgn & bus.srcb[31];
    assign a_mag_in  = sa_in ? -bus.srca : bus.srca;
    assign b_mag_in  = sb_in ? -bus.srcb : bus.srcb;

`ifdef ALU_MULDIV_FAST_MULT_EN
    assign acc_init    = is_mul_in ? {32'b0, a_mag_in} * {32'b0, b_mag_in} : {32'b0, a_mag_in};
    assign first_state = is_mul_in ? FIX : RUN;
`else
    assign acc_init    = {32'b0, a_mag_in};
    assign first_state = RUN;
`endif

    // acc low half starts as multiplier/dividend; high half accumulates product/remainder
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    assign div_r    = acc[63:31];
    assign div_d    = div_r - {1'b0, b_mag};
    assign acc_step = is_div ? {div_d[32] ? div_r[31:0] : div_d[31:0], acc[30:0], ~div_d[32]}
                             : {mul_sum, acc[31:1]};

    assign prod   = (sa ^ sb) ? -acc : acc;
    assign quo    = (sa ^ sb) ? -acc[31:0] : acc[31:0];
    assign rem    = sa ? -acc[63:32] : acc[63:32];
    assign hi_fix = is_div ? (b_mag == 32'd0 ? a_raw : rem) : prod[63:32];
    assign lo_fix = is_div ? (b_mag == 32'd0 ? 32'hFFFF_FFFF : quo) : prod[31:0];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        next_state = state == IDLE ? (start ? first_state : IDLE)
                   : state == RUN  ? (count == 5'd31 ? FIX : RUN)
                   : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= 5'd0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            a_raw  <= 32'd0;
            b_mag  <= 32'd0;
            acc    <= 64'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= state == FIX;
            if (idle_wr && op == MTHI) hi_q <= bus.srca;
            if (idle_wr && op == MTLO) lo_q <= bus.srca;
            if (start) begin
                count  <= 5'd0;
                is_div <= is_div_in;
                sa     <= sa_in;
                sb     <= sb_in;
                a_raw  <= bus.srca;
                b_mag  <= b_mag_in;
                acc    <= acc_init;
            end else if (state == RUN) begin
                count <= count + 5'd1;
                acc   <= acc_step;
            end else if (state == FIX) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = state != IDLE;
    assign bus.done = done_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized scoreboard bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
    localparam logic [4:0] MULTU = 5'b00111;
    localparam logic [4:0] MULT  = 5'b01000;
    localparam logic [4:0] DIV   = 5'b01111;
    localparam logic [4:0] DIVU  = 5'b10000;
    localparam logic [4:0] MTHI  = 5'b10001;
    localparam logic [4:0] MTLO  = 5'b10010;
`ifdef ALU_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_muldiv_if bus ();
    alu_muldiv dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    exp_t sb[$];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            MULTU:   return {32'b0, a} * {32'b0, b};
            MULT:    return 64'(x * y);
            DIVU:    return b == 32'd0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return b == 32'd0 ? {a, 32'hFFFF_FFFF} : {32'(x % y), 32'(x / y)};
        endcase
    endfunction

    function automatic string op_name(input logic [4:0] op);
        case (op)
            MULTU:   return "multu";
            MULT:    return "mult";
            DIVU:    return "divu";
            DIV:     return "div";
            MTHI:    return "mthi";
            default: return "mtlo";
        endcase
    endfunction

    // Monitor: pops an expectation on every done pulse and checks result, latency and HI/LO hold.
    int          blen = 0;
    bit          hold_bad = 0;
    logic        pbusy = 0, pdone = 0;
    logic [63:0] phl = '0;
    exp_t        cur;
    always @(negedge clk) begin
        if (!reset_n) begin
            blen = 0;
            hold_bad = 0;
        end else begin
            if (bus.busy && pbusy && {bus.hi, bus.lo} !== phl) hold_bad = 1;
            if (bus.busy) blen++;
            if (bus.done) begin
                if (sb.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
                else begin
                    cur = sb.pop_front();
                    chk({cur.name, "_hilo"}, {bus.hi, bus.lo}, {cur.hi, cur.lo});
                    chk({cur.name, "_busy_cycles"}, 64'(blen), 64'(cur.lat));
                    chk({cur.name, "_hold_during_run"}, 64'(hold_bad), 64'd0);
                    chk({cur.name, "_done_single"}, 64'(pdone), 64'd0);
                end
                blen = 0;
                hold_bad = 0;
            end
        end
        pbusy = bus.busy;
        pdone = bus.done;
        phl = {bus.hi, bus.lo};
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        wait_idle();
        bus.valid = 1'b1;
        bus.alucontrol = op;
        bus.srca = a;
        bus.srcb = b;
        if (op == MULT || op == MULTU || op == DIV || op == DIVU) begin
            r = model(op, a, b);
            sb.push_back('{r[63:32], r[31:0], (op == MULT || op == MULTU) ? MUL_LAT : DIV_LAT, op_name(op)});
        end
        @(negedge clk);
        bus.valid = 1'b0;
        if (op == MTHI) chk("mthi", 64'(bus.hi), 64'(a));
        if (op == MTLO) chk("mtlo", 64'(bus.lo), 64'(a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ops[6];
        logic [31:0] a, b;
        int n;
        ops = '{MULTU, MULT, DIV, DIVU, MTHI, MTLO};
        bus.valid = 1'b0;
        bus.alucontrol = 5'd0;
        bus.srca = 32'd0;
        bus.srcb = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        issue(DIVU, 32'd7, 32'd0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(MTHI, 32'h1234_5678, 32'd0);

        issue(MULTU, 32'd6, 32'd7);
        bus.valid = 1'b1;
        bus.alucontrol = MTLO;
        bus.srca = 32'hAA;
        @(negedge clk);
        bus.alucontrol = MTHI;
        @(negedge clk);
        bus.valid = 1'b0;

        issue(DIVU, 32'hDEAD_BEEF, 32'd1234);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_hi", 64'(bus.hi), 64'd0);
        chk("midreset_lo", 64'(bus.lo), 64'd0);
        chk("midreset_done", 64'(bus.done), 64'd0);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(MULTU, 32'd3, 32'd4);

        issue(DIVU, 32'd100, 32'd7);
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 64'(bus.done), 64'd1);
        issue(MULTU, 32'd5, 32'd5);
        chk("b2b_prev_held", {bus.hi, bus.lo}, {32'd2, 32'd14});
        chk("b2b_busy", 64'(bus.busy), 64'd1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(0, 3);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = -b[15:0];
                default: ;
            endcase
            issue(ops[$urandom_range(0, 5)], a, b);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
